// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter in front of a single memory bus. A request is
//   sampled in IDLE, its fields are registered, then issued for one cycle
//   (ISSUE). Writes return straight to IDLE; reads hold the bus for RD_LAT
//   cycles (WAIT), capture the read data and present it for one cycle (RESP).
//
//   Optional feature macro: ARB_RR_EN
//     defined   -> ties go to the requester that did not win last
//     undefined -> m0 always wins ties
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   m0_*/m1_* req, wr, addr,
//             wdata, op           requester inputs (req held until gnt)
//   m0_gnt/m1_gnt                 one-cycle grant pulse in the issue cycle
//   m0_rvalid/m1_rvalid           one-cycle read-data-valid pulse
//   rdata_out                     registered read data
//   dm_w, dm_r, addr, wdata,
//   dm_op                         bus request strobes and fields
//   rdata                         bus read data
//   busy                          high whenever not IDLE
module mem_arbiter #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [2:0]  m0_op,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [2:0]  m1_op,
   output logic        m0_gnt,
   output logic        m1_gnt,
   output logic        m0_rvalid,
   output logic        m1_rvalid,
   output logic [31:0] rdata_out,
   output logic        dm_w,
   output logic        dm_r,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   output logic [2:0]  dm_op,
   input  logic [31:0] rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Counter reload: WAIT lasts RD_LAT cycles, the last one has count 0.
   localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

   state_t      state_q, state_d;
   logic        own_q;          // owner of the transaction: 0 = m0, 1 = m1
   logic        wr_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  op_q;
   logic [2:0]  cnt_q;
   logic [31:0] rdata_out_q;
   logic        any_req;
   logic        win_m1;

   assign any_req = m0_req | m1_req;

`ifdef ARB_RR_EN
   logic last_q;                // last winner: 0 = m0, 1 = m1

   // On a tie, m1 wins only if m0 won last time.
   assign win_m1 = m1_req & (~m0_req | ~last_q);
`else
   assign win_m1 = m1_req & ~m0_req;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ISSUE;
         ISSUE:   state_d = wr_q ? IDLE : WAIT;
         WAIT:    if (cnt_q == 3'd0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request capture, wait counter and read-data register. The request is
   // captured only in IDLE, so later input changes cannot disturb it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         own_q       <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         op_q        <= 3'd0;
         cnt_q       <= 3'd0;
         rdata_out_q <= 32'd0;
`ifdef ARB_RR_EN
         last_q      <= 1'b1;
`endif
      end else begin
         if (state_q == IDLE && any_req) begin
            own_q   <= win_m1;
            wr_q    <= win_m1 ? m1_wr    : m0_wr;
            addr_q  <= win_m1 ? m1_addr  : m0_addr;
            wdata_q <= win_m1 ? m1_wdata : m0_wdata;
            op_q    <= win_m1 ? m1_op    : m0_op;
         end
         if (state_q == ISSUE && !wr_q) begin
            cnt_q <= CNT_INIT;
         end else if (state_q == WAIT && cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
         end
         if (state_q == WAIT && cnt_q == 3'd0) begin
            rdata_out_q <= rdata;
         end
`ifdef ARB_RR_EN
         // Updated in ISSUE, i.e. exactly when a grant is shown.
         if (state_q == ISSUE) begin
            last_q <= own_q;
         end
`endif
      end
   end

   // Output logic: everything is zero except what the current state drives.
   always_comb begin
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      dm_w      = 1'b0;
      dm_r      = 1'b0;
      addr      = 32'd0;
      wdata     = 32'd0;
      dm_op     = 3'd0;
      busy      = (state_q != IDLE);
      case (state_q)
         ISSUE: begin
            addr   = addr_q;
            wdata  = wdata_q;
            dm_op  = op_q;
            dm_w   = wr_q;
            dm_r   = ~wr_q;
            m0_gnt = ~own_q;
            m1_gnt = own_q;
         end
         WAIT: begin
            addr  = addr_q;
            dm_op = op_q;
            dm_r  = 1'b1;
         end
         RESP: begin
            m0_rvalid = ~own_q;
            m1_rvalid = own_q;
         end
         default: ;
      endcase
   end

   assign rdata_out = rdata_out_q;

endmodule
